// File: rtl/biriscv_mul_pkg.sv
// ----------------------------------------------------------------------------
// biriscv_mul_pkg
// Shared definitions for the pipelined RV32M/RV64M multiplier:
//   - MUL_OP_* : op_i encodings (equal to funct3[1:0] of the M-extension ops)
//   - STAGES_MIN / STAGES_MAX : legal range of the issue-to-result latency
//   - mul_operand_signs() : per-op signedness of the rs1/rs2 operands
// ----------------------------------------------------------------------------
package biriscv_mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'd0;
    localparam logic [1:0] MUL_OP_MULH   = 2'd1;
    localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
    localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

    localparam int unsigned STAGES_MIN = 2;
    localparam int unsigned STAGES_MAX = 4;

    // Returns {a_signed, b_signed}. rs1 is signed for MULH/MULHSU and rs2
    // only for MULH. MUL takes the low half, which is independent of
    // signedness, so both operands are treated as unsigned there.
    function automatic logic [1:0] mul_operand_signs(input logic [1:0] op);
        logic a_signed;
        logic b_signed;
        a_signed = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
        b_signed = (op == MUL_OP_MULH);
        return {a_signed, b_signed};
    endfunction

endpackage

// File: rtl/biriscv_mul_tag_pipe.sv
// ----------------------------------------------------------------------------
// biriscv_mul_tag_pipe
// DEPTH-deep shift register of {valid, rd, data} with stall and clear.
//   clk_i, rst_n    : clock, synchronous active-low reset
//   hold_i          : freeze every stage
//   clear_i         : load zero into every stage (wins over hold_i)
//   valid_i/rd_i/data_i : entry shifted into the first stage
//   valid_o/rd_o/data_o : last stage contents
//   stage_valid_o   : valid bit of each stage, bit 0 = first stage
// ----------------------------------------------------------------------------
module biriscv_mul_tag_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             hold_i,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [4:0]       rd_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [4:0]       rd_o,
    output logic [WIDTH-1:0] data_o,
    output logic [DEPTH-1:0] stage_valid_o
);

    logic [DEPTH-1:0] valid_q;
    logic [4:0]       rd_q   [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_n || clear_i) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (!hold_i) begin
            valid_q[0] <= valid_i;
            rd_q[0]    <= rd_i;
            data_q[0]  <= data_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                rd_q[i]    <= rd_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o       = valid_q[DEPTH-1];
    assign rd_o          = rd_q[DEPTH-1];
    assign data_o        = data_q[DEPTH-1];
    assign stage_valid_o = valid_q;

endmodule

// File: rtl/biriscv_mul_pipe.sv
// ----------------------------------------------------------------------------
// biriscv_mul_pipe
// Fully pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU), one op per
// cycle, STAGES cycles from issue to result.
//   clk_i, rst_n     : clock, synchronous active-low reset
//   valid_i, op_i    : issue strobe and op (funct3[1:0])
//   rd_i, a_i, b_i   : destination tag and rs1/rs2 operands
//   hold_i           : stall, freezes all stages (valid_i ignored)
//   flush_i          : kill all in-flight ops (wins over hold_i)
//   valid_o, rd_o, result_o : completing op, straight from the last stage
//   stage_valid_o    : bit k set when stage E(k+1) holds a valid op
// E1 registers the extended operands; the product is formed between E1 and
// E2; E2..E_STAGES are a tag pipe carrying {valid, rd, result}.
// ----------------------------------------------------------------------------
module biriscv_mul_pipe
    import biriscv_mul_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [1:0]        op_i,
    input  logic [4:0]        rd_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [4:0]        rd_o,
    output logic [XLEN-1:0]   result_o,
    output logic [STAGES-1:0] stage_valid_o
);

    if ((STAGES < STAGES_MIN) || (STAGES > STAGES_MAX) ||
        ((XLEN != 32) && (XLEN != 64))) begin : g_param_check
        $error("biriscv_mul_pipe: unsupported XLEN=%0d / STAGES=%0d", XLEN, STAGES);
    end

    // ---------------- E1: operand capture ----------------
    logic            e1_valid_q, e1_valid_d;
    logic            e1_hi_q,    e1_hi_d;
    logic [4:0]      e1_rd_q,    e1_rd_d;
    logic [XLEN:0]   e1_a_q,     e1_a_d;
    logic [XLEN:0]   e1_b_q,     e1_b_d;
    logic [1:0]      op_signs;

    assign op_signs = mul_operand_signs(op_i);

    // Bubbles load all-zero so an idle pipe carries zero results and tags.
    always_comb begin
        e1_valid_d = 1'b0;
        e1_hi_d    = 1'b0;
        e1_rd_d    = '0;
        e1_a_d     = '0;
        e1_b_d     = '0;
        if (valid_i) begin
            e1_valid_d = 1'b1;
            e1_hi_d    = (op_i != MUL_OP_MUL);
            e1_rd_d    = rd_i;
            e1_a_d     = {op_signs[1] & a_i[XLEN-1], a_i};
            e1_b_d     = {op_signs[0] & b_i[XLEN-1], b_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n || flush_i) begin
            e1_valid_q <= 1'b0;
            e1_hi_q    <= 1'b0;
            e1_rd_q    <= '0;
            e1_a_q     <= '0;
            e1_b_q     <= '0;
        end else if (!hold_i) begin
            e1_valid_q <= e1_valid_d;
            e1_hi_q    <= e1_hi_d;
            e1_rd_q    <= e1_rd_d;
            e1_a_q     <= e1_a_d;
            e1_b_q     <= e1_b_d;
        end
    end

    // ---------------- Product (E1 -> E2) ----------------
    // Operands are sign-extended to the full product width so a plain
    // unsigned multiply yields the signed (XLEN+1)x(XLEN+1) product.
    logic [2*XLEN+1:0] prod_a;
    logic [2*XLEN+1:0] prod_b;
    logic [2*XLEN+1:0] prod;
    logic [XLEN-1:0]   e1_result;
    logic              unused_prod_top;

    assign prod_a          = {{(XLEN+1){e1_a_q[XLEN]}}, e1_a_q};
    assign prod_b          = {{(XLEN+1){e1_b_q[XLEN]}}, e1_b_q};
    assign prod            = prod_a * prod_b;
    assign e1_result       = e1_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    assign unused_prod_top = ^prod[2*XLEN+1:2*XLEN];

    // ---------------- E2..E_STAGES ----------------
    logic [STAGES-2:0] tail_stage_valid;

    biriscv_mul_tag_pipe #(
        .DEPTH (STAGES - 1),
        .WIDTH (XLEN)
    ) u_tag_pipe (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .hold_i        (hold_i),
        .clear_i       (flush_i),
        .valid_i       (e1_valid_q),
        .rd_i          (e1_rd_q),
        .data_i        (e1_result),
        .valid_o       (valid_o),
        .rd_o          (rd_o),
        .data_o        (result_o),
        .stage_valid_o (tail_stage_valid)
    );

    assign stage_valid_o = {tail_stage_valid, e1_valid_q};

endmodule

// File: tb/tb_biriscv_mul_pipe.sv
// ----------------------------------------------------------------------------
// tb_biriscv_mul_pipe
// Drives one shared stimulus stream into three multiplier configurations
// (XLEN/STAGES = 32/2, 32/3, 64/4). Accepted ops are pushed into a per-config
// expectation queue together with the arithmetic result; a monitor on the
// falling edge compares every cycle's outputs against the queue.
// ----------------------------------------------------------------------------
module tb_biriscv_mul_pipe;

    localparam int NCFG = 3;

    function automatic int cfg_xlen(input int c);
        return (c == 2) ? 64 : 32;
    endfunction

    function automatic int cfg_stages(input int c);
        return c + 2;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [1:0]  op_in = '0;
    logic [4:0]  rd_in = '0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        s32_en = 1'b0;
    logic [31:0] s32 = '0;
    logic        s64_en = 1'b0;
    logic [63:0] s64 = '0;
    logic        mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic        v0, v1, v2;
    logic [4:0]  rd0, rd1, rd2;
    logic [31:0] r0, r1;
    logic [63:0] r2;
    logic [1:0]  sv0;
    logic [2:0]  sv1;
    logic [3:0]  sv2;

    biriscv_mul_pipe #(.XLEN(32), .STAGES(2)) u_dut_32_2 (
        .clk_i(clk), .rst_n(rst_n), .valid_i(valid_in), .op_i(op_in), .rd_i(rd_in),
        .a_i(a_in[31:0]), .b_i(b_in[31:0]), .hold_i(hold), .flush_i(flush),
        .valid_o(v0), .rd_o(rd0), .result_o(r0), .stage_valid_o(sv0));

    biriscv_mul_pipe #(.XLEN(32), .STAGES(3)) u_dut_32_3 (
        .clk_i(clk), .rst_n(rst_n), .valid_i(valid_in), .op_i(op_in), .rd_i(rd_in),
        .a_i(a_in[31:0]), .b_i(b_in[31:0]), .hold_i(hold), .flush_i(flush),
        .valid_o(v1), .rd_o(rd1), .result_o(r1), .stage_valid_o(sv1));

    biriscv_mul_pipe #(.XLEN(64), .STAGES(4)) u_dut_64_4 (
        .clk_i(clk), .rst_n(rst_n), .valid_i(valid_in), .op_i(op_in), .rd_i(rd_in),
        .a_i(a_in), .b_i(b_in), .hold_i(hold), .flush_i(flush),
        .valid_o(v2), .rd_o(rd2), .result_o(r2), .stage_valid_o(sv2));

    logic        vo  [NCFG];
    logic [4:0]  rdo [NCFG];
    logic [63:0] reso[NCFG];
    logic [3:0]  svo [NCFG];

    assign vo[0] = v0;   assign rdo[0] = rd0;   assign reso[0] = {32'd0, r0};   assign svo[0] = {2'd0, sv0};
    assign vo[1] = v1;   assign rdo[1] = rd1;   assign reso[1] = {32'd0, r1};   assign svo[1] = {1'd0, sv1};
    assign vo[2] = v2;   assign rdo[2] = rd2;   assign reso[2] = r2;            assign svo[2] = sv2;

    // ---------------- Reference model ----------------
    // RISC-V M semantics: interpret each operand as signed or unsigned per
    // op, take the exact product, return the low or high XLEN bits.
    function automatic logic [63:0] ref_mul(input int xlen, input logic [1:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
        logic              a_s, b_s;
        logic signed [129:0] sa, sb, p, sh;
        logic [63:0]       r;
        a_s = (op == 2'd1) || (op == 2'd2);
        b_s = (op == 2'd1);
        if (xlen == 32) begin
            sa = a_s ? $signed({{98{a[31]}}, a[31:0]}) : $signed({98'd0, a[31:0]});
            sb = b_s ? $signed({{98{b[31]}}, b[31:0]}) : $signed({98'd0, b[31:0]});
        end else begin
            sa = a_s ? $signed({{66{a[63]}}, a}) : $signed({66'd0, a});
            sb = b_s ? $signed({{66{b[63]}}, b}) : $signed({66'd0, b});
        end
        p  = sa * sb;
        sh = (op == 2'd0) ? p : (p >>> xlen);
        r  = sh[63:0];
        if (xlen == 32) r[63:32] = '0;
        return r;
    endfunction

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] res;
        logic        has_spec;
        logic [63:0] spec;
        int          tick;
    } exp_t;

    exp_t q [NCFG][$];
    int   adv [NCFG];

    initial for (int c = 0; c < NCFG; c++) adv[c] = 0;

    // An op is accepted on a non-hold, non-flush, non-reset edge; it becomes
    // visible STAGES-1 advancing edges later and leaves on the next advance.
    always @(posedge clk) begin
        for (int c = 0; c < NCFG; c++) begin
            if (!rst_n || flush) begin
                q[c].delete();
            end else if (!hold) begin
                adv[c] = adv[c] + 1;
                while (q[c].size() > 0 && (adv[c] - q[c][0].tick + 1) > cfg_stages(c))
                    void'(q[c].pop_front());
                if (valid_in) begin
                    exp_t e;
                    e.rd       = rd_in;
                    e.res      = ref_mul(cfg_xlen(c), op_in, a_in, b_in);
                    e.has_spec = (cfg_xlen(c) == 32) ? s32_en : s64_en;
                    e.spec     = (cfg_xlen(c) == 32) ? {32'd0, s32} : s64;
                    e.tick     = adv[c];
                    q[c].push_back(e);
                end
            end
        end
    end

    // ---------------- Monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < NCFG; c++) begin
                logic [3:0] exp_sv;
                bit         exp_v;
                exp_sv = '0;
                for (int i = 0; i < q[c].size(); i++) begin
                    int age;
                    age = adv[c] - q[c][i].tick + 1;
                    if (age >= 1 && age <= cfg_stages(c)) exp_sv[age-1] = 1'b1;
                end
                checks++;
                if (svo[c] !== exp_sv) begin
                    errors++;
                    $display("FAIL cfg%0d stage_valid got %b want %b at %0t", c, svo[c], exp_sv, $time);
                end
                exp_v = (q[c].size() > 0) && ((adv[c] - q[c][0].tick + 1) == cfg_stages(c));
                checks++;
                if (exp_v) begin
                    if (vo[c] !== 1'b1 || rdo[c] !== q[c][0].rd || reso[c] !== q[c][0].res) begin
                        errors++;
                        $display("FAIL cfg%0d result got v=%b rd=%0d res=%h want v=1 rd=%0d res=%h at %0t",
                                 c, vo[c], rdo[c], reso[c], q[c][0].rd, q[c][0].res, $time);
                    end
                    if (q[c][0].has_spec) begin
                        checks++;
                        if (reso[c] !== q[c][0].spec) begin
                            errors++;
                            $display("FAIL cfg%0d directed got %h want %h at %0t",
                                     c, reso[c], q[c][0].spec, $time);
                        end
                    end
                end else if (vo[c] !== 1'b0 || rdo[c] !== 5'd0 || reso[c] !== 64'd0) begin
                    errors++;
                    $display("FAIL cfg%0d idle got v=%b rd=%0d res=%h want v=0 rd=0 res=0 at %0t",
                             c, vo[c], rdo[c], reso[c], $time);
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] rd,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic h, input logic f, input logic r,
                         input logic e32, input logic [31:0] x32,
                         input logic e64, input logic [63:0] x64);
        @(posedge clk);
        #1;
        valid_in = v;  op_in = op;  rd_in = rd;  a_in = a;  b_in = b;
        hold = h;  flush = f;  rst_n = r;
        s32_en = e32;  s32 = x32;  s64_en = e64;  s64 = x64;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic hold_cycles(input int n);
        for (int i = 0; i < n; i++)
            drive(1, 2'd3, 5'd31, 64'hDEAD, 64'hBEEF, 1, 0, 1, 0, 0, 0, 0);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 64'hFFFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'h0000_0000_8000_0000;
            3: return 64'd0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(2);

        // single MUL, result and one-shot valid
        drive(1, 2'd0, 5'd5, 64'd7, 64'h0000_0000_FFFF_FFFD, 0, 0, 1, 1, 32'hFFFF_FFEB, 0, 0);
        idle(6);

        // back-to-back high-half ops
        drive(1, 2'd1, 5'd1, 64'h8000_0000, 64'h8000_0000, 0, 0, 1, 1, 32'h4000_0000, 0, 0);
        drive(1, 2'd2, 5'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 1, 1, 32'hFFFF_FFFF, 0, 0);
        drive(1, 2'd3, 5'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 1, 1, 32'hFFFF_FFFE, 0, 0);
        idle(6);

        // hold delays completion, outputs frozen meanwhile
        drive(1, 2'd0, 5'd7, 64'd3, 64'd5, 0, 0, 1, 1, 32'd15, 1, 64'd15);
        hold_cycles(3);
        idle(6);

        // flush kills two in-flight ops; next op completes normally
        drive(1, 2'd0, 5'd8, 64'd11, 64'd13, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 2'd3, 5'd9, 64'd17, 64'd19, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 2'd1, 5'd10, 64'd23, 64'd29, 1, 1, 1, 0, 0, 0, 0);
        drive(1, 2'd0, 5'd11, 64'd6, 64'd7, 0, 0, 1, 1, 32'd42, 1, 64'd42);
        idle(6);

        // reset with hold asserted loses the in-flight op
        drive(1, 2'd0, 5'd12, 64'd9, 64'd9, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 2'd0, 5'd13, 64'd4, 64'd4, 1, 0, 0, 0, 0, 0, 0);
        idle(6);

        // 64-bit corner products
        drive(1, 2'd3, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1,
              1, 32'hFFFF_FFFE, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        drive(1, 2'd0, 5'd15, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 0, 0, 1,
              1, 32'hFFFF_FFFA, 1, 64'hFFFF_FFFF_FFFF_FFFA);
        idle(6);

        // randomized traffic with occasional hold / flush / reset
        for (int i = 0; i < 500; i++) begin
            logic v, h, f, r;
            v = ($urandom_range(0, 9) < 7);
            h = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 29) == 0);
            r = !($urandom_range(0, 99) == 0);
            drive(v, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  rand_operand(), rand_operand(), h, f, r, 0, 0, 0, 0);
        end
        idle(8);
        @(negedge clk);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
